// File: rtl/outmem_pkg.sv
// Shared types and constants for the output-memory drain path.
// Optional feature macro used by this block: OUTRD_LAST_EN (adds m_last to output_mem_reader).
package outmem_pkg;

    // Drain controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Skid storage behind the memory read port; the credit rule is sized to this
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/outrd_fifo2.sv
// Two-entry FIFO with fall-through head: a word pushed into an empty FIFO is
// visible on head in the same cycle, so a word can arrive and leave together.
// Part of output_mem_reader (optional feature macro there: OUTRD_LAST_EN).
module outrd_fifo2
    import outmem_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Head bypasses storage when empty so the arriving word is presented at once
    assign head  = (r_count == 2'd0) ? push_data : r_mem[r_rd_ptr];
    assign valid = (r_count != 2'd0) || push;
    assign count = r_count;

    // Storage, pointers and occupancy; push+pop on empty stores nothing net
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) r_rd_ptr <= ~r_rd_ptr;
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/output_mem_reader.sv
// Drains the CNN output memory after a layer completes: issues reads from
// address 0, absorbs the memory's 1-cycle read latency through a 2-entry
// FIFO and streams words on a valid/ready port.
// Optional feature macro: OUTRD_LAST_EN (adds m_last, high with the final word).
//
// Handshake: a word transfers on every rising clk edge where m_valid && m_ready.
// m_valid never drops and m_data_out never changes while m_valid && !m_ready.
module output_mem_reader
    import outmem_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int SIZE    = 64,
    localparam int LOGSIZE = $clog2(SIZE)
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LOGSIZE:0]   num_words,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [LOGSIZE-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]   mem_data_in,
    output logic [WIDTH-1:0]   m_data_out,
    output logic               m_valid,
    input  logic               m_ready,
`ifdef OUTRD_LAST_EN
    output logic               m_last,
`endif
    output state_t             dbg_state
);

    localparam logic [LOGSIZE:0] SIZE_W = (LOGSIZE+1)'(SIZE);
    localparam logic [LOGSIZE:0] ONE_W  = (LOGSIZE+1)'(1);

    state_t             r_state;
    logic [LOGSIZE:0]   r_count;
    logic [LOGSIZE:0]   r_issued;
    logic [LOGSIZE:0]   r_delivered;
    logic               r_inflight;
    logic               r_busy;
    logic               r_done;
    logic [LOGSIZE-1:0] r_last_addr;

    logic [LOGSIZE:0]   w_start_count;
    logic               w_accept_start;
    logic [1:0]         w_fifo_count;
    logic               w_fifo_valid;
    logic [WIDTH-1:0]   w_fifo_head;
    logic               w_pop;
    logic [2:0]         w_occupancy;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_last_pop;

    assign w_start_count  = (num_words > SIZE_W) ? SIZE_W : num_words;
    assign w_accept_start = (r_state == ST_IDLE) && start;
    assign w_pop          = w_fifo_valid && m_ready;
    // Words that will sit in the FIFO after this edge, before any new read lands
    assign w_occupancy    = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit_ok    = w_occupancy < 3'(FIFO_DEPTH);
    assign w_issue        = (r_state == ST_DRAIN) && (r_issued < r_count) && w_credit_ok;
    assign w_last_pop     = w_pop && ((r_delivered + ONE_W) == r_count);

    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = w_issue ? r_issued[LOGSIZE-1:0] : r_last_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign m_valid     = w_fifo_valid;
    assign m_data_out  = w_fifo_head;
    assign dbg_state   = r_state;
`ifdef OUTRD_LAST_EN
    assign m_last      = w_fifo_valid && ((r_delivered + ONE_W) == r_count);
`endif

    // The read issued last cycle returns now and is captured by the FIFO
    outrd_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (r_inflight),
        .push_data (mem_data_in),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .valid     (w_fifo_valid),
        .count     (w_fifo_count)
    );

    // Control FSM: latch the clamped word count, track drain, pulse done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count <= w_start_count;
                        if (w_start_count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Issue/deliver counters, in-flight flag and the held read address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issued    <= '0;
            r_delivered <= '0;
            r_inflight  <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept_start) begin
                r_issued    <= '0;
                r_delivered <= '0;
            end else begin
                if (w_issue) begin
                    r_issued    <= r_issued + ONE_W;
                    r_last_addr <= r_issued[LOGSIZE-1:0];
                end
                if (w_pop) r_delivered <= r_delivered + ONE_W;
            end
        end
    end

endmodule
